// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants for the operand fetch stage and its register scoreboard.
//   DATA_WIDTH : operand/register width
//   ADDR_WIDTH : register address width
//   OP_WIDTH   : opcode/control width carried through the stage
//   REG_COUNT  : number of architectural registers
//   ZERO_REG   : hard-wired zero register index
package operand_fetch_stage_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int OP_WIDTH   = 6;
    localparam int REG_COUNT  = 32;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// Register scoreboard: one pending bit per architectural register, set when a
// writer issues and cleared by writeback or by flushing the in-flight writer.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   set_en / set_addr              : a writer of set_addr issues this cycle
//   clr_en / clr_addr              : writeback to clr_addr this cycle
//   flush_clr_en / flush_clr_addr  : in-flight writer to flush_clr_addr is killed
//   rs1_addr, rs2_addr, rd_addr    : lookup addresses
//   pend_rs1, pend_rs2, pend_rd    : effective pending bits (writeback-adjusted)
module operand_fetch_stage_reg_scoreboard #(
    parameter int ADDR_WIDTH = operand_fetch_stage_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic                  flush_clr_en,
    input  logic [ADDR_WIDTH-1:0] flush_clr_addr,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  pend_rs1,
    output logic                  pend_rs2,
    output logic                  pend_rd
);
    import operand_fetch_stage_pkg::*;

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // A register being written back this cycle is no longer a hazard: the
    // bypass path already delivers its value.
    function automatic logic eff(input logic [ADDR_WIDTH-1:0] a);
        return pending[a] && !(clr_en && (clr_addr == a));
    endfunction

    assign pend_rs1 = eff(rs1_addr);
    assign pend_rs2 = eff(rs2_addr);
    assign pend_rd  = eff(rd_addr);

    // Clears first, then set, so a new issue to the same register wins over
    // the completion of the older write.
    always_comb begin
        pending_nxt = pending;
        if (clr_en)       pending_nxt[clr_addr]       = 1'b0;
        if (flush_clr_en) pending_nxt[flush_clr_addr] = 1'b0;
        if (set_en)       pending_nxt[set_addr]       = 1'b1;
        pending_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Register-read/issue stage between decode and execute. Drives the register
// file read addresses, bypasses same-cycle writeback, stalls on RAW/WAW
// hazards using a pending-write scoreboard and registers resolved operands
// into the ID/EX register.
// Handshakes: a transfer happens on a cycle where valid and ready are both 1
// at the rising edge; valid, once raised, stays up with stable payload until
// the transfer; ready may depend on the cycle's inputs but not on valid.
// Ports:
//   Clk, Rst_N                        : clock, async active-low reset
//   in_Valid/in_Ready                 : upstream handshake
//   rs1_Addr, rs2_Addr, rd_Addr       : decoded register fields (rd 0 = no write)
//   imm_in, use_Imm, op_in            : immediate, operand-B select, opcode
//   addr_A/addr_B, data_outA/B        : register file read ports
//   wb_En, wb_Addr, wb_Data           : writeback (also drives regfile write)
//   flush                             : kill the output register
//   out_Valid/out_Ready               : downstream handshake
//   opA, opB, out_Rd, out_Op          : ID/EX register contents
module operand_fetch_stage #(
    parameter int DATA_WIDTH = operand_fetch_stage_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = operand_fetch_stage_pkg::ADDR_WIDTH,
    parameter int OP_WIDTH   = operand_fetch_stage_pkg::OP_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst_N,
    input  logic                  in_Valid,
    output logic                  in_Ready,
    input  logic [ADDR_WIDTH-1:0] rs1_Addr,
    input  logic [ADDR_WIDTH-1:0] rs2_Addr,
    input  logic [ADDR_WIDTH-1:0] rd_Addr,
    input  logic [DATA_WIDTH-1:0] imm_in,
    input  logic                  use_Imm,
    input  logic [OP_WIDTH-1:0]   op_in,
    output logic [ADDR_WIDTH-1:0] addr_A,
    output logic [ADDR_WIDTH-1:0] addr_B,
    input  logic [DATA_WIDTH-1:0] data_outA,
    input  logic [DATA_WIDTH-1:0] data_outB,
    input  logic                  wb_En,
    input  logic [ADDR_WIDTH-1:0] wb_Addr,
    input  logic [DATA_WIDTH-1:0] wb_Data,
    input  logic                  flush,
    output logic                  out_Valid,
    input  logic                  out_Ready,
    output logic [DATA_WIDTH-1:0] opA,
    output logic [DATA_WIDTH-1:0] opB,
    output logic [ADDR_WIDTH-1:0] out_Rd,
    output logic [OP_WIDTH-1:0]   out_Op
);
    import operand_fetch_stage_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic                  pend_rs1;
    logic                  pend_rs2;
    logic                  pend_rd;
    logic                  hazard;
    logic                  fire;
    logic                  set_en;
    logic                  clr_en;
    logic                  flush_clr_en;
    logic [DATA_WIDTH-1:0] op_a_res;
    logic [DATA_WIDTH-1:0] op_b_res;

    assign addr_A = rs1_Addr;
    assign addr_B = rs2_Addr;

    // The register file write only lands at the clock edge, so a same-cycle
    // writeback must be forwarded here.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0] rf_data
    );
        if (rs == ZERO_ADDR)             return '0;
        else if (wb_En && wb_Addr == rs) return wb_Data;
        else                             return rf_data;
    endfunction

    assign op_a_res = resolve(rs1_Addr, data_outA);
    assign op_b_res = use_Imm ? imm_in : resolve(rs2_Addr, data_outB);

    assign hazard = pend_rs1
                  | (pend_rs2 & ~use_Imm)
                  | (pend_rd & (rd_Addr != ZERO_ADDR));

    assign in_Ready = !hazard && (!out_Valid || out_Ready) && !flush;
    assign fire     = in_Valid && in_Ready;

    assign set_en       = fire && (rd_Addr != ZERO_ADDR);
    assign clr_en       = wb_En && (wb_Addr != ZERO_ADDR);
    // The killed instruction's destination write will never happen.
    assign flush_clr_en = flush && out_Valid;

    operand_fetch_stage_reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sb (
        .clk            (Clk),
        .rst_n          (Rst_N),
        .set_en         (set_en),
        .set_addr       (rd_Addr),
        .clr_en         (clr_en),
        .clr_addr       (wb_Addr),
        .flush_clr_en   (flush_clr_en),
        .flush_clr_addr (out_Rd),
        .rs1_addr       (rs1_Addr),
        .rs2_addr       (rs2_Addr),
        .rd_addr        (rd_Addr),
        .pend_rs1       (pend_rs1),
        .pend_rs2       (pend_rs2),
        .pend_rd        (pend_rd)
    );

    // Payload only changes on fire, so a stalled output holds by default.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            out_Valid <= 1'b0;
            opA       <= '0;
            opB       <= '0;
            out_Rd    <= '0;
            out_Op    <= '0;
        end else if (fire) begin
            out_Valid <= 1'b1;
            opA       <= op_a_res;
            opB       <= op_b_res;
            out_Rd    <= rd_Addr;
            out_Op    <= op_in;
        end else if (flush || (out_Valid && out_Ready)) begin
            out_Valid <= 1'b0;
        end
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Register-read/issue stage sitting between decode and execute.
- Drives the register file's two combinational read addresses and consumes its two read data outputs.
- Bypasses the same-cycle writeback and tracks pending destination writes in a scoreboard to stall RAW/WAW hazards.
- Registers resolved operands into the ID/EX pipeline register with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 64: operand/register width.
- ADDR_WIDTH, 5: register address width (32 registers).
- OP_WIDTH, 6: opcode/control field width, passed through.

Ports:
- Clk  input  1  clock, rising edge.
- Rst_N  input  1  asynchronous active-low reset.
- in_Valid  input  1  decoded instruction present.
- in_Ready  output  1  stage accepts the instruction this cycle.
- rs1_Addr  input  ADDR_WIDTH  source register 1.
- rs2_Addr  input  ADDR_WIDTH  source register 2.
- rd_Addr  input  ADDR_WIDTH  destination register; 0 means no write.
- imm_in  input  DATA_WIDTH  sign-extended immediate.
- use_Imm  input  1  operand B = immediate, rs2 ignored.
- op_in  input  OP_WIDTH  opcode/control.
- addr_A  output  ADDR_WIDTH  register file read address A (= rs1_Addr, combinational).
- addr_B  output  ADDR_WIDTH  register file read address B (= rs2_Addr, combinational).
- data_outA  input  DATA_WIDTH  register file read data A.
- data_outB  input  DATA_WIDTH  register file read data B.
- wb_En  input  1  writeback this cycle (same signals drive the register file write port).
- wb_Addr  input  ADDR_WIDTH  writeback register.
- wb_Data  input  DATA_WIDTH  writeback value.
- flush  input  1  synchronous kill of this stage's output register.
- out_Valid  output  1  ID/EX register holds a valid instruction.
- out_Ready  input  1  execute accepts this cycle.
- opA  output  DATA_WIDTH  resolved operand A.
- opB  output  DATA_WIDTH  resolved operand B or immediate.
- out_Rd  output  ADDR_WIDTH  registered rd.
- out_Op  output  OP_WIDTH  registered opcode.

Behaviour:
- Clock and reset:
  - One clock, Clk. Reset Rst_N is asynchronous, active-low.
  - On reset: out_Valid=0; opA, opB, out_Rd, out_Op = 0; scoreboard all 0.
- Operand resolution (combinational, per source rs):
  - rs==0 -> 0.
  - Else if wb_En and wb_Addr==rs -> wb_Data. Needed because the register file write lands only at the clock edge.
  - Else -> register file data.
  - opB = imm_in when use_Imm.
- Scoreboard:
  - pending[1..31]; pending[0] is constantly 0.
  - pending_eff[r] = pending[r] and not (wb_En and wb_Addr==r).
- Hazard:
  - Hazard when any of: pending_eff[rs1]; pending_eff[rs2] with use_Imm=0; pending_eff[rd] with rd!=0 (WAW).
  - in_Ready = !hazard and (!out_Valid or out_Ready) and !flush.
- Fire:
  - fire = in_Valid and in_Ready.
  - On fire: capture operands, rd, and op; set out_Valid=1 next cycle. Latency issue -> out_Valid is 1 cycle.
  - On fire with rd!=0: set pending[rd].
- Out_Valid clear and hold:
  - Drain (out_Valid and out_Ready) without fire: out_Valid=0.
  - out_Valid and !out_Ready: hold all outputs stable.
- Writeback:
  - wb_En with wb_Addr!=0 clears pending[wb_Addr].
  - Same-cycle set and clear of the same bit: set wins, because the new issue supersedes.
  - wb_Addr==0 is ignored.
- Flush:
  - Next cycle: out_Valid=0.
  - If out_Valid, clear pending[out_Rd] (that write is cancelled).
  - No fire in a flush cycle.
  - Flush overrides out_Ready.
- in_Valid without fire: the instruction must be held by upstream; the stage does not latch it.
- Reset mid-operation: everything returns to reset values immediately; in-flight pending bits are lost.

Decomposition:
- Shared package: DATA_WIDTH, ADDR_WIDTH, OP_WIDTH, REG_COUNT=32, ZERO_REG=0.
- Sub-module reg_scoreboard:
  - Contains the 32-bit pending vector.
  - Inputs: set_en/set_addr, clr_en/clr_addr, flush_clr_en/flush_clr_addr.
  - Outputs: pending_eff lookups for rs1, rs2, rd.

Test Plan:
1. Reset, then issue op rs1=3, rs2=4, rd=5, regfile A=0x11, B=0x22 -> next cycle out_Valid=1, opA=0x11, opB=0x22, out_Rd=5, pending[5]=1.
2. Issue rs1=5 while pending[5]=1, wb_En=0 -> in_Ready=0 for 3 cycles. Then wb_En=1, wb_Addr=5, wb_Data=0xABCD -> fires that cycle, opA=0xABCD, pending[5]=0.
3. rs1=0, rs2=0, use_Imm=1, imm_in=0xFFFF_FFFF_FFFF_FFF0, with stale data_outA=0x99 -> opA=0, opB=imm; rd=0 leaves the scoreboard unchanged.
4. out_Ready=0 for 4 cycles with a valid output -> opA/opB/out_Rd stable and in_Ready=0. Then out_Ready=1 with a new in_Valid -> back-to-back transfer, no bubble.
5. Flush with out_Valid=1, out_Rd=7 -> next cycle out_Valid=0, pending[7]=0. A following instruction reading r7 issues without a stall.
6. Issue rd=9 in the same cycle as wb_En=1, wb_Addr=9 clearing an older write -> pending[9]=1 afterwards. Assert Rst_N low mid-stall -> out_Valid=0 and scoreboard cleared asynchronously.
